// File: rtl/prompt_gen_ctrl.sv
// Text-prompt sequencer: maps HID key presses and firmware-generated characters
// onto the HDMI text-cell RAM, and owns that RAM's single write port.
module prompt_gen_ctrl #(
   parameter int unsigned COLS    = 80,
   parameter int unsigned ROWS    = 30,
   parameter int unsigned MAX_GEN = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] keycode,
   input  logic [7:0]  generated_ascii,
   input  logic [11:0] generate_count,
   output logic        execute,
   output logic        busy,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [11:0] cursor
);

   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned GW    = $clog2(MAX_GEN + 1);

   localparam logic [11:0]   LAST_CELL = 12'(CELLS - 1);
   localparam logic [11:0]   LAST_COL  = 12'(COLS - 1);
   localparam logic [11:0]   LAST_ROW  = 12'(ROWS - 1);
   localparam logic [11:0]   COLS_W    = 12'(COLS);
   localparam logic [12:0]   CELLS_W   = 13'(CELLS);
   localparam logic [GW-1:0] GEN_LIMIT = GW'(MAX_GEN);

   localparam logic [7:0] K_ENTER = 8'h28;
   localparam logic [7:0] K_ESC   = 8'h29;
   localparam logic [7:0] K_BKSP  = 8'h2A;

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_GEN} state_e;

   typedef struct packed {
      logic [11:0] row;
      logic [11:0] col;
      logic [11:0] cur;
   } pos_t;

   state_e        state_q, state_d;
   pos_t          pos_q, pos_d;
   logic [7:0]    k_q, k_prev_q, a_q;
   logic [11:0]   c_q, c_prev_q, c_prev_d;
   logic [12:0]   clr_q, clr_d;
   logic [GW-1:0] gen_q, gen_d;
   logic          wr_en_q, wr_en_d;
   logic [11:0]   wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;

   logic          key_ev, cnt_ev;
   logic [8:0]    kc;
   pos_t          back;
   logic          unused_keycode;

   assign unused_keycode = ^keycode[31:8];

   // Row/col/cursor move together as counters so no row*COLS multiply is needed.
   function automatic pos_t advance(input pos_t p);
      pos_t n;
      n = p;
      if (p.cur == LAST_CELL) begin
         n = '0;
      end else begin
         n.cur = p.cur + 12'd1;
         if (p.col == LAST_COL) begin
            n.col = '0;
            n.row = p.row + 12'd1;
         end else begin
            n.col = p.col + 12'd1;
         end
      end
      return n;
   endfunction

   function automatic pos_t newline(input pos_t p);
      pos_t n;
      n     = p;
      n.col = '0;
      if (p.row == LAST_ROW) begin
         n.row = '0;
         n.cur = '0;
      end else begin
         n.row = p.row + 12'd1;
         n.cur = p.cur - p.col + COLS_W;
      end
      return n;
   endfunction

   function automatic pos_t retreat(input pos_t p);
      pos_t n;
      n     = p;
      n.cur = p.cur - 12'd1;
      if (p.col == '0) begin
         n.col = LAST_COL;
         n.row = p.row - 12'd1;
      end else begin
         n.col = p.col - 12'd1;
      end
      return n;
   endfunction

   // Returns {printable, ascii}.
   function automatic logic [8:0] key_char(input logic [7:0] k);
      if (k >= 8'h04 && k <= 8'h1D) return {1'b1, k + 8'h5D};
      if (k >= 8'h1E && k <= 8'h26) return {1'b1, k + 8'h13};
      if (k == 8'h27)               return {1'b1, 8'h30};
      if (k == 8'h2C)               return {1'b1, 8'h20};
      return 9'h000;
   endfunction

   assign key_ev = (k_q != k_prev_q) && (k_q != 8'h00);
   assign cnt_ev = (c_q != c_prev_q);
   assign kc     = key_char(k_q);
   assign back   = retreat(pos_q);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d   = state_q;
      pos_d     = pos_q;
      c_prev_d  = c_prev_q;
      clr_d     = clr_q;
      gen_d     = gen_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      unique case (state_q)
         S_CLEAR: begin
            if (clr_q == CELLS_W) begin
               state_d = S_IDLE;
               pos_d   = '0;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = clr_q[11:0];
               wr_data_d = 8'h20;
               clr_d     = clr_q + 13'd1;
            end
         end
         S_IDLE: begin
            if (key_ev) begin
               if (kc[8]) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = pos_q.cur;
                  wr_data_d = kc[7:0];
                  pos_d     = advance(pos_q);
               end else if (k_q == K_BKSP && pos_q.cur != '0) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = back.cur;
                  wr_data_d = 8'h20;
                  pos_d     = back;
               end else if (k_q == K_ENTER) begin
                  pos_d    = newline(pos_q);
                  c_prev_d = c_q;
                  gen_d    = '0;
                  state_d  = S_GEN;
               end
            end
         end
         S_GEN: begin
            // Esc wins over a same-cycle count change, which is then dropped.
            if (key_ev && k_q == K_ESC) begin
               pos_d    = newline(pos_q);
               c_prev_d = c_q;
               state_d  = S_IDLE;
            end else if (gen_q == GEN_LIMIT) begin
               pos_d   = newline(pos_q);
               state_d = S_IDLE;
            end else if (cnt_ev) begin
               c_prev_d = c_q;
               if (a_q == 8'h00) begin
                  pos_d   = newline(pos_q);
                  state_d = S_IDLE;
               end else if (a_q == 8'h0A) begin
                  pos_d = newline(pos_q);
               end else begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = pos_q.cur;
                  wr_data_d = a_q;
                  pos_d     = advance(pos_q);
                  gen_d     = gen_q + GW'(1);
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; the async reset
   // returns every register, including the clear sweep counter, to its start value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_CLEAR;
         pos_q     <= '0;
         k_q       <= '0;
         k_prev_q  <= '0;
         a_q       <= '0;
         c_q       <= '0;
         c_prev_q  <= '0;
         clr_q     <= '0;
         gen_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 8'h20;
      end else begin
         state_q   <= state_d;
         pos_q     <= pos_d;
         k_q       <= keycode[7:0];
         k_prev_q  <= k_q;
         a_q       <= generated_ascii;
         c_q       <= generate_count;
         c_prev_q  <= c_prev_d;
         clr_q     <= clr_d;
         gen_q     <= gen_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign execute = (state_q == S_GEN);
   assign busy    = (state_q != S_IDLE);
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign cursor  = pos_q.cur;

endmodule

// File: tb/tb_prompt_gen_ctrl.sv
// Directed bench for prompt_gen_ctrl: clear sweep, key typing, backspace,
// firmware generation, wrap, Esc abort and mid-generation reset.
module tb_prompt_gen_ctrl;

   localparam int CELLS = 80 * 30;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] keycode;
   logic [7:0]  generated_ascii;
   logic [11:0] generate_count;
   logic        execute, busy, wr_en;
   logic [11:0] wr_addr, cursor;
   logic [7:0]  wr_data;

   int n_tests = 0;
   int n_fail  = 0;

   prompt_gen_ctrl dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .keycode         (keycode),
      .generated_ascii (generated_ascii),
      .generate_count  (generate_count),
      .execute         (execute),
      .busy            (busy),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .cursor          (cursor)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a keycode at a falling edge and wait until its effect is visible.
   task automatic key(input logic [7:0] k);
      keycode = {24'h0, k};
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic fw(input logic [11:0] c, input logic [7:0] a);
      generate_count  = c;
      generated_ascii = a;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic exp_wr(input string tag, input logic [11:0] addr, input logic [7:0] data,
                         input logic [11:0] cur);
      check({tag, "_en"},   {31'h0, wr_en}, 32'h1);
      check({tag, "_addr"}, {20'h0, wr_addr}, {20'h0, addr});
      check({tag, "_data"}, {24'h0, wr_data}, {24'h0, data});
      check({tag, "_cur"},  {20'h0, cursor}, {20'h0, cur});
   endtask

   task automatic exp_nowr(input string tag, input logic [11:0] cur);
      check({tag, "_en"},  {31'h0, wr_en}, 32'h0);
      check({tag, "_cur"}, {20'h0, cursor}, {20'h0, cur});
   endtask

   task automatic clear_sweep(input string tag);
      for (int i = 0; i < CELLS; i++) begin
         @(negedge clk);
         check(tag, {11'h0, wr_en, wr_addr, wr_data}, {11'h0, 1'b1, i[11:0], 8'h20});
      end
      @(negedge clk);
      check({tag, "_done_en"},   {31'h0, wr_en}, 32'h0);
      check({tag, "_done_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_done_cur"},  {20'h0, cursor}, 32'h0);
   endtask

   initial begin
      logic [11:0] cnt;
      int          nwr;

      reset_n         = 1'b0;
      keycode         = '0;
      generated_ascii = '0;
      generate_count  = '0;
      repeat (3) @(negedge clk);
      check("rst_execute", {31'h0, execute}, 32'h0);
      check("rst_busy",    {31'h0, busy}, 32'h1);
      check("rst_wr_en",   {31'h0, wr_en}, 32'h0);
      check("rst_wr_addr", {20'h0, wr_addr}, 32'h0);
      check("rst_wr_data", {24'h0, wr_data}, 32'h20);
      check("rst_cursor",  {20'h0, cursor}, 32'h0);

      reset_n = 1'b1;
      clear_sweep("clear1");

      // Typing with releases, then a held key.
      key(8'h0B); exp_wr("h0", 12'd0, 8'h68, 12'd1);
      key(8'h00); exp_nowr("rel0", 12'd1);
      key(8'h0B); exp_wr("h1", 12'd1, 8'h68, 12'd2);
      key(8'h00);
      key(8'h0C); exp_wr("i2", 12'd2, 8'h69, 12'd3);
      nwr = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (wr_en) nwr++;
      end
      check("hold_writes", nwr, 0);

      // Backspace down to cell 0, then once more with no effect.
      key(8'h2A); exp_wr("bs3", 12'd2, 8'h20, 12'd2);
      key(8'h00);
      key(8'h2A); exp_wr("bs2", 12'd1, 8'h20, 12'd1);
      key(8'h00);
      key(8'h2A); exp_wr("bs1", 12'd0, 8'h20, 12'd0);
      key(8'h00);
      key(8'h2A); exp_nowr("bs0", 12'd0);
      key(8'h00);

      // Key map corners, ignored keys and Esc in IDLE.
      key(8'h04); exp_wr("k_a",   12'd0, 8'h61, 12'd1);
      key(8'h1E); exp_wr("k_1",   12'd1, 8'h31, 12'd2);
      key(8'h27); exp_wr("k_0",   12'd2, 8'h30, 12'd3);
      key(8'h2C); exp_wr("k_spc", 12'd3, 8'h20, 12'd4);
      key(8'h1D); exp_wr("k_z",   12'd4, 8'h7A, 12'd5);
      key(8'h3A); exp_nowr("k_f1", 12'd5);
      key(8'h29); exp_nowr("k_esc_idle", 12'd5);
      check("esc_idle_exec", {31'h0, execute}, 32'h0);

      // Enter and a short generation ending in 0x00.
      key(8'h28);
      exp_nowr("enter", 12'd80);
      check("enter_exec", {31'h0, execute}, 32'h1);
      check("enter_busy", {31'h0, busy}, 32'h1);
      key(8'h00);
      fw(12'd1, 8'h4F); exp_wr("gen_O", 12'd80, 8'h4F, 12'd81);
      fw(12'd2, 8'h4B); exp_wr("gen_K", 12'd81, 8'h4B, 12'd82);
      fw(12'd3, 8'h0A); exp_nowr("gen_lf", 12'd160);
      check("gen_lf_exec", {31'h0, execute}, 32'h1);
      fw(12'd4, 8'h00); exp_nowr("gen_nul", 12'd240);
      check("gen_nul_exec", {31'h0, execute}, 32'h0);
      check("gen_nul_busy", {31'h0, busy}, 32'h0);

      // Walk to the last cell inside GEN and wrap.
      cnt = 12'd4;
      key(8'h28);
      check("gen2_cur", {20'h0, cursor}, 32'd320);
      key(8'h00);
      for (int i = 0; i < 25; i++) begin
         cnt = cnt + 12'd1;
         fw(cnt, 8'h0A);
      end
      check("lf_walk_cur", {20'h0, cursor}, 32'd2320);
      for (int i = 0; i < 79; i++) begin
         cnt = cnt + 12'd1;
         fw(cnt, 8'h78);
      end
      check("x_walk_cur", {20'h0, cursor}, 32'd2399);
      cnt = cnt + 12'd1;
      fw(cnt, 8'h5A); exp_wr("wrap_Z", 12'd2399, 8'h5A, 12'd0);

      // Esc together with a count change.
      keycode         = 32'h29;
      cnt             = cnt + 12'd1;
      generate_count  = cnt;
      generated_ascii = 8'h51;
      @(negedge clk);
      @(negedge clk);
      exp_nowr("esc_gen", 12'd80);
      check("esc_gen_exec", {31'h0, execute}, 32'h0);
      keycode = '0;
      @(negedge clk);
      exp_nowr("esc_after", 12'd80);

      // Count jumping by more than one commits exactly one character.
      key(8'h28);
      check("gen3_cur", {20'h0, cursor}, 32'd160);
      key(8'h00);
      cnt = cnt + 12'd3;
      fw(cnt, 8'h4A); exp_wr("jump_J", 12'd160, 8'h4A, 12'd161);
      @(negedge clk);
      exp_nowr("jump_once", 12'd161);
      check("jump_exec", {31'h0, execute}, 32'h1);

      // Asynchronous reset in the middle of generation.
      reset_n = 1'b0;
      #1;
      check("arst_exec",   {31'h0, execute}, 32'h0);
      check("arst_busy",   {31'h0, busy}, 32'h1);
      check("arst_cursor", {20'h0, cursor}, 32'h0);
      check("arst_wr_en",  {31'h0, wr_en}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      clear_sweep("clear2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prompt_gen_ctrl.md
# prompt_gen_ctrl

Sequencing controller between the USB keyboard, the MicroBlaze text-generation firmware and the HDMI text-cell RAM. It turns HID key presses into on-screen prompt characters. On Enter it raises `execute` to the firmware and streams each firmware-generated ASCII character into the text RAM. It is the single owner and scheduler of the text RAM write port.

## Interface
- `COLS`, 80, characters per text row
- `ROWS`, 30, text rows; `COLS*ROWS` must be ≤ 4096
- `MAX_GEN`, 1024, maximum generated characters accepted per request

- `clk`  in  1  system clock (100 MHz)
- `reset_n`  in  1  asynchronous, active-low reset
- `keycode`  in  32  USB keycode GPIO word; only `keycode[7:0]` (first HID slot) is used
- `generated_ascii`  in  8  character last published by firmware
- `generate_count`  in  12  firmware character counter; incremented by 1 after each new `generated_ascii`
- `execute`  out  1  level request to firmware to run generation
- `busy`  out  1  high in CLEAR and GEN
- `wr_en`  out  1  text RAM write strobe, single-cycle
- `wr_addr`  out  12  text RAM cell address, `row*COLS+col`
- `wr_data`  out  8  ASCII byte to write
- `cursor`  out  12  current cell address

## Operation
- Input stage: `keycode[7:0]`, `generated_ascii` and `generate_count` are registered once (`k_q`, `a_q`, `c_q`). `k_prev` and `c_prev` hold the previous values.
- Key press event: `k_q != k_prev && k_q != 0`. Releases and held keys generate no events.
- Key map:
  - 0x04–0x1D → 'a'–'z' (0x61+k−4)
  - 0x1E–0x26 → '1'–'9'
  - 0x27 → '0'
  - 0x2C → 0x20
  - 0x28 Enter, 0x2A Backspace, 0x29 Esc
  - All other keycodes are ignored.
- Cursor: `row`, `col` and `cursor` are tracked as counters; `cursor` is never computed by multiply.
  - Advance: `col+1`; at `col==COLS-1`, `col=0, row+1`; at the last cell, wrap to 0.
  - Newline: `col=0`, `row+1`, wrapping to 0 after `ROWS-1`.
- FSM states:
  - CLEAR: entered on reset. Writes 0x20 to every cell 0..`COLS*ROWS-1`, one per cycle, then → IDLE with cursor 0.
  - IDLE:
    - Printable key: write the char at `cursor`, then advance.
    - Backspace: if `cursor!=0`, retreat one cell (col−1, or col=COLS−1 and row−1), then write 0x20 at the new cursor. At `cursor==0`, no write.
    - Enter: newline, latch `c_prev=c_q`, clear `gen_n`, → GEN.
    - Esc: ignored.
  - GEN: `execute=1`. On each `c_q != c_prev`, set `c_prev=c_q` and commit exactly one character, `a_q`, even if the count jumped by more than 1:
    - 0x00: newline, → IDLE.
    - 0x0A: newline, no write.
    - Any other byte: write at `cursor`, advance, `gen_n+1`.
    - When `gen_n` reaches `MAX_GEN`, newline, → IDLE.
    - Esc key: newline, → IDLE; the pending count change in that same cycle is discarded.
    - All other keys are ignored.
- Priority in a single cycle: Esc > count change > other keys.

## Timing
- Reset values:
  - Outputs: `execute=0`, `busy=1` (CLEAR), `wr_en=0`, `wr_addr=0`, `wr_data=0x20`, `cursor=0`.
  - Internal: `k_prev=0`, `c_prev=0`.
- First CLEAR write occurs the first cycle after `reset_n` deasserts. CLEAR lasts exactly `COLS*ROWS` cycles. `busy` falls the cycle after the last write.
- Key and count latency: `wr_en` asserts exactly 2 cycles after the `keycode` or `generate_count` input change. `cursor` reflects the advance in the same cycle as `wr_en`.
- Enter: `execute` rises 2 cycles after `keycode` changes to 0x28.
- `execute` falls in the same cycle the terminating event (0x00, `MAX_GEN`, Esc) is processed. `busy` falls with it.
- At most one write per cycle. Bytes `wr_addr`/`wr_data` are valid only when `wr_en=1` and hold otherwise.
- `reset_n` asserted mid-GEN or mid-CLEAR: all state returns to reset values immediately (asynchronously), and CLEAR restarts.

## Test plan
- Reset release: `wr_en` high for 2400 consecutive cycles, addresses 0..2399, data 0x20. Then `busy=0` and `cursor=0`.
- Keycode sequence 0x0B, 0x00, 0x0B, 0x00, 0x0C: writes 'h'@0, 'h'@1, 'i'@2, `cursor=3`. Holding 0x0C for 50 cycles produces no further writes.
- Backspace at cursor 3: write 0x20@2, `cursor=2`. Backspace at cursor 0: no write, cursor stays 0.
- Enter at cursor 5: `execute=1` after 2 cycles, `cursor=80`. Firmware sequence of count/ascii pairs 1/'O', 2/'K', 3/0x0A, 4/0x00: writes 'O'@80 and 'K'@81; then `cursor=160` after the 0x0A and `cursor=240` after the 0x00; `execute=0` after the 0x00.
- Wrap: at cursor 2399 in GEN, a count change with 'Z' writes 'Z'@2399 and sets `cursor=0`. Esc keycode 0x29 at the same cycle as a count change: no write, `execute=0`, `cursor=80`.
- Assert `reset_n=0` mid-GEN: `execute` drops immediately (asynchronously). Release: a full CLEAR sweep runs again.
